// File: rtl/load_extend_pipe.sv
// Load-data lane select + sign/zero extend: 2-cycle latency, one result per cycle.
// Two-stage valid/ready pipe; in_ready falls only when both stages are full and out_ready is low.
module load_extend_pipe #(
  parameter  int DATA_W = 32,
  localparam int OFFS_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFFS_W-1:0] in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign
);

  localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);
  localparam logic [DATA_W-1:0] MASK_F = {DATA_W{1'b1}};

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_lane_q, s1_lane_d;
  logic [1:0]        s1_size_q, s1_size_d;
  logic              s1_sgn_q, s1_sgn_d;
  logic              s1_mis_q, s1_mis_d;
  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_mis_q, s2_mis_d;

  logic              s1_adv;
  logic              in_xfer;
  logic              s2_load;
  logic              in_mis;
  logic [DATA_W-1:0] ext_mask;
  logic              ext_sbit;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    s1_adv   = !s2_vld_q || out_ready;
    in_ready = !s1_vld_q || s1_adv;
    in_xfer  = in_valid && in_ready;
    s2_load  = s1_vld_q && s1_adv;
  end

  // Alignment: the offset's low bits must be zero up to the access size.
  always_comb begin
    in_mis = 1'b0;
    case (in_size)
      2'b00:   in_mis = 1'b0;
      2'b01:   in_mis = in_offset[0];
      2'b10:   in_mis = |in_offset[1:0];
      default: in_mis = |in_offset;
    endcase
  end

  always_comb begin
    ext_mask = MASK_F;
    ext_sbit = 1'b0;
    case (s1_size_q)
      2'b00: begin
        ext_mask = MASK_B;
        ext_sbit = s1_lane_q[7];
      end
      2'b01: begin
        ext_mask = MASK_H;
        ext_sbit = s1_lane_q[15];
      end
      2'b10: begin
        ext_mask = MASK_W;
        ext_sbit = s1_lane_q[31];
      end
      default: begin
        ext_mask = MASK_F;
        ext_sbit = s1_lane_q[DATA_W-1];
      end
    endcase
    ext_data = (s1_lane_q & ext_mask) | ({DATA_W{s1_sgn_q & ext_sbit}} & ~ext_mask);
    if (s1_mis_q) begin
      ext_data = '0;
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_lane_d = s1_lane_q;
    s1_size_d = s1_size_q;
    s1_sgn_d  = s1_sgn_q;
    s1_mis_d  = s1_mis_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_mis_d  = s2_mis_q;

    if (in_xfer) begin
      s1_lane_d = in_data >> {in_offset, 3'b000};
      s1_size_d = in_size;
      s1_sgn_d  = in_signed;
      s1_mis_d  = in_mis;
    end
    if (in_ready) begin
      s1_vld_d = in_valid;
    end

    if (s2_load) begin
      s2_data_d = ext_data;
    end
    // Misalign flag tracks the entry in s2, so it drops when s2 drains empty.
    if (s1_adv) begin
      s2_vld_d = s1_vld_q;
      s2_mis_d = s1_vld_q && s1_mis_q;
    end

    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
      s2_mis_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_lane_q <= '0;
      s1_size_q <= 2'b00;
      s1_sgn_q  <= 1'b0;
      s1_mis_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_mis_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_lane_q <= s1_lane_d;
      s1_size_q <= s1_size_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_mis_q  <= s1_mis_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_mis_q  <= s2_mis_d;
    end
  end

  assign out_valid    = s2_vld_q;
  assign out_data     = s2_data_q;
  assign out_misalign = s2_mis_q;

endmodule
